// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory and its write buffer: word/address
// widths, default buffer depth and the store entry layout.
package data_mem_pkg;

    localparam int WORDSIZE   = 16;
    localparam int ADDRSIZE   = 5;
    localparam int WBUF_DEPTH = 4;

    typedef struct packed {
        logic [ADDRSIZE-1:0] addr;
        logic [WORDSIZE-1:0] data;
    } store_entry_t;

    // Build a store entry from its address and data fields.
    function automatic store_entry_t make_entry(
        input logic [ADDRSIZE-1:0] addr,
        input logic [WORDSIZE-1:0] data
    );
        store_entry_t e;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/data_write_buffer_chk.sv
// Occupancy sanity checks for the write buffer.
module data_write_buffer_chk #(
    parameter int depth = 4,
    parameter int cw    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [cw-1:0] count,
    input  logic          wa_en,
    input  logic          wb_en
);

    // Count stays within 0..depth; an underflow would wrap above depth.
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        int'(count) <= depth);

    // A push is only issued when there is room for it.
    a_push_room: assert property (@(posedge clk) disable iff (!rst_n)
        wa_en |-> (int'(count) <= depth - 1));

    // A dual push needs two free entries.
    a_dual_room: assert property (@(posedge clk) disable iff (!rst_n)
        (wa_en && wb_en) |-> (int'(count) <= depth - 2));

endmodule

// File: rtl/wbuf_fifo_2w1r.sv
// In-order storage for the write buffer: two write slots per cycle (tail and
// tail+1) and one read slot at head. Pointers wrap modulo depth; the occupancy
// counter tells a full buffer from an empty one.
module wbuf_fifo_2w1r
    import data_mem_pkg::*;
#(
    parameter int ew    = ADDRSIZE + WORDSIZE,
    parameter int depth = WBUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wa_en,
    input  logic [ew-1:0]              wa_data,
    input  logic                       wb_en,
    input  logic [ew-1:0]              wb_data,
    input  logic                       pop,
    output logic [ew-1:0]              rd_data,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int pw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);

    logic [ew-1:0] mem_r [depth];
    logic [pw-1:0] head_r;
    logic [pw-1:0] tail_r;
    logic [cw-1:0] count_r;
    logic [pw-1:0] head_next_s;
    logic [pw-1:0] tail_next_s;
    logic [pw-1:0] tail_plus1_s;
    logic [cw-1:0] count_next_s;
    logic          pop_ok_s;
    logic          wb_ok_s;

    // Next pointer/count values; the second slot only counts alongside the first.
    always_comb begin
        pop_ok_s     = pop & (count_r != {cw{1'b0}});
        wb_ok_s      = wa_en & wb_en;
        tail_plus1_s = tail_r + pw'(1);
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        if (pop_ok_s) begin
            head_next_s = head_r + pw'(1);
        end else begin
            head_next_s = head_r;
        end
        if (wb_ok_s) begin
            tail_next_s = tail_r + pw'(2);
        end else if (wa_en) begin
            tail_next_s = tail_r + pw'(1);
        end else begin
            tail_next_s = tail_r;
        end
        count_next_s = count_r + cw'(wa_en) + cw'(wb_ok_s) - cw'(pop_ok_s);
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r  <= {pw{1'b0}};
            tail_r  <= {pw{1'b0}};
            count_r <= {cw{1'b0}};
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
        end
    end

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (rst_n && wa_en) begin
            mem_r[tail_r] <= wa_data;
        end
        if (rst_n && wb_ok_s) begin
            mem_r[tail_plus1_s] <= wb_data;
        end
    end

    assign rd_data = mem_r[head_r];
    assign count   = count_r;
    assign empty   = (count_r == {cw{1'b0}});
    assign full    = (count_r == cw'(depth));

endmodule

// File: rtl/data_write_buffer.sv
// Write buffer between the two FU write-back ports and the single memory
// write port. Stores are queued in program order (port 0 older than port 1)
// and drained one per cycle whenever the buffer is non-empty.
module data_write_buffer
    import data_mem_pkg::*;
#(
    parameter int wordsize = WORDSIZE,
    parameter int addrsize = ADDRSIZE,
    parameter int depth    = WBUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req0_valid,
    input  logic [addrsize-1:0]        req0_addr,
    input  logic [wordsize-1:0]        req0_data,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [addrsize-1:0]        req1_addr,
    input  logic [wordsize-1:0]        req1_data,
    output logic                       req1_ready,
    output logic                       mem_we,
    output logic [addrsize-1:0]        mem_waddr,
    output logic [wordsize-1:0]        mem_wdata,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int ew = addrsize + wordsize;
    localparam int cw = $clog2(depth + 1);

    logic          push0_s;
    logic          push1_s;
    logic          wa_en_s;
    logic          wb_en_s;
    logic [ew-1:0] wa_data_s;
    logic [ew-1:0] wb_data_s;
    logic [ew-1:0] head_s;
    logic [cw-1:0] count_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;

    // Readiness depends only on the registered count so it never loops back
    // through valid or drain.
    always_comb begin
        req0_ready = (count_s <= cw'(depth - 1));
        req1_ready = (count_s <= cw'(depth - 2));
    end

    // Accept gating and slot mapping: the older accepted store goes to tail,
    // a second one to tail+1; a lone port-1 store takes the tail slot.
    always_comb begin
        push0_s   = req0_valid & req0_ready;
        push1_s   = req1_valid & req1_ready;
        wa_en_s   = push0_s | push1_s;
        wb_en_s   = push0_s & push1_s;
        wb_data_s = {req1_addr, req1_data};
        if (push0_s) begin
            wa_data_s = {req0_addr, req0_data};
        end else begin
            wa_data_s = {req1_addr, req1_data};
        end
    end

    // Drain the head entry whenever something is queued; idle port reads zero.
    always_comb begin
        pop_s  = !empty_s;
        mem_we = !empty_s;
        if (!empty_s) begin
            mem_waddr = head_s[ew-1:wordsize];
            mem_wdata = head_s[wordsize-1:0];
        end else begin
            mem_waddr = {addrsize{1'b0}};
            mem_wdata = {wordsize{1'b0}};
        end
    end

    wbuf_fifo_2w1r #(
        .ew    (ew),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wa_en   (wa_en_s),
        .wa_data (wa_data_s),
        .wb_en   (wb_en_s),
        .wb_data (wb_data_s),
        .pop     (pop_s),
        .rd_data (head_s),
        .count   (count_s),
        .empty   (empty_s),
        .full    (full_s)
    );

    data_write_buffer_chk #(
        .depth (depth),
        .cw    (cw)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count_s),
        .wa_en (wa_en_s),
        .wb_en (wb_en_s)
    );

    assign count = count_s;
    assign empty = empty_s;
    assign full  = full_s;

endmodule

// File: tb/tb_data_write_buffer.sv
// Self-checking bench for data_write_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_data_write_buffer;
    import data_mem_pkg::*;

    localparam int AW    = ADDRSIZE;
    localparam int WW    = WORDSIZE;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int MSIZE = 2 ** AW;

    logic          clk;
    logic          rst_n;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [WW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [WW-1:0] req1_data;
    logic          req1_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [WW-1:0] mem_wdata;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    int n_checks = 0;
    int n_errors = 0;

    store_entry_t  model_q[$];
    logic [WW-1:0] model_mem [MSIZE];
    logic [WW-1:0] tb_mem    [MSIZE];

    data_write_buffer #(
        .wordsize (WW),
        .addrsize (AW),
        .depth    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array fed by the DUT write port (writes on reset edges are dropped).
    always @(posedge clk) begin
        if (rst_n && mem_we) begin
            tb_mem[mem_waddr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with what the model queue implies.
    task automatic check_outputs();
        int n;
        n = model_q.size();
        check("count",      32'(count),      32'(n));
        check("empty",      32'(empty),      (n == 0) ? 32'd1 : 32'd0);
        check("full",       32'(full),       (n == DEPTH) ? 32'd1 : 32'd0);
        check("req0_ready", 32'(req0_ready), (n <= DEPTH - 1) ? 32'd1 : 32'd0);
        check("req1_ready", 32'(req1_ready), (n <= DEPTH - 2) ? 32'd1 : 32'd0);
        check("mem_we",     32'(mem_we),     (n != 0) ? 32'd1 : 32'd0);
        if (n != 0) begin
            check("mem_waddr", 32'(mem_waddr), 32'(model_q[0].addr));
            check("mem_wdata", 32'(mem_wdata), 32'(model_q[0].data));
        end else begin
            check("mem_waddr", 32'(mem_waddr), 32'd0);
            check("mem_wdata", 32'(mem_wdata), 32'd0);
        end
    endtask

    // One cycle: check outputs, drive inputs, advance the model over the edge.
    task automatic step(input logic rn,
                        input logic v0, input logic [AW-1:0] a0, input logic [WW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [WW-1:0] d1);
        int n;
        check_outputs();
        rst_n      = rn;
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
        n = model_q.size();
        if (!rn) begin
            model_q.delete();
        end else begin
            if (n > 0) begin
                model_mem[model_q[0].addr] = model_q[0].data;
                void'(model_q.pop_front());
            end
            if (v0 && (n <= DEPTH - 1)) model_q.push_back(make_entry(a0, d0));
            if (v1 && (n <= DEPTH - 2)) model_q.push_back(make_entry(a1, d1));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(1'b1, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
        end
    endtask

    initial begin
        for (int i = 0; i < MSIZE; i++) begin
            model_mem[i] = 16'h0000;
            tb_mem[i]    = 16'h0000;
        end
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req0_addr  = 5'd0;
        req0_data  = 16'h0000;
        req1_valid = 1'b0;
        req1_addr  = 5'd0;
        req1_data  = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then a single store.
        step(1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
        step(1'b1, 1'b1, 5'd5, 16'h00A1, 1'b0, 5'd0, 16'h0000);
        idle(2);

        // Dual store to the same address: last write wins.
        step(1'b1, 1'b1, 5'd3, 16'h0011, 1'b1, 5'd3, 16'h0022);
        idle(3);
        check("rdback3", 32'(tb_mem[3]), 32'h0000_0022);

        // Backpressure: dual stores every cycle.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, AW'(i), WW'(16'h0100 + i), 1'b1, AW'(i + 8), WW'(16'h0200 + i));
        end
        idle(5);

        // Wrap: ten back-to-back single stores with data 1..10.
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, AW'(i + 16), WW'(i), 1'b0, 5'd0, 16'h0000);
        end
        idle(3);

        // Reset while three entries are queued.
        step(1'b1, 1'b1, 5'd10, 16'h00B1, 1'b1, 5'd11, 16'h00B2);
        step(1'b1, 1'b1, 5'd12, 16'h00B3, 1'b1, 5'd13, 16'h00B4);
        step(1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
        step(1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
        idle(2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, AW'($urandom), WW'($urandom),
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, AW'($urandom), WW'($urandom));
        end
        idle(6);

        // Memory image written by the DUT matches the model image.
        for (int i = 0; i < MSIZE; i++) begin
            check("memimg", 32'(tb_mem[i]), 32'(model_mem[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
